// File: rtl/rand_pkg.sv
// Shared definitions for the LFSR random generator: FSM states and mode encodings.
package rand_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR advance, Fibonacci or Galois form selected at run time.
module lfsr_step
  import rand_pkg::*;
#(
  parameter int unsigned       WIDTH    = 6,
  parameter logic [WIDTH-1:0]  FIB_TAPS = 6'b110000,
  parameter logic [WIDTH-1:0]  GAL_POLY = 6'b100001
) (
  input  logic [WIDTH-1:0] state,
  input  logic             mode,
  output logic [WIDTH-1:0] next_state
);

  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;

  always_comb begin
    fib_fb     = ^(state & FIB_TAPS);
    fib_next   = {state[WIDTH-2:0], fib_fb};
    // Galois: shift in zero, fold the polynomial back when the MSB falls out
    gal_next   = {state[WIDTH-2:0], 1'b0} ^ (state[WIDTH-1] ? GAL_POLY : '0);
    next_state = (mode == MODE_GAL) ? gal_next : fib_next;
  end

endmodule

// File: rtl/rand_lfsr_gen.sv
// Pseudo-random draw engine: seeds an LFSR, runs STEPS shifts per start pulse,
// and publishes the low OUT_W bits of the final state with a one-cycle done.
module rand_lfsr_gen
  import rand_pkg::*;
#(
  parameter int unsigned      WIDTH      = 6,
  parameter logic [WIDTH-1:0] FIB_TAPS   = 6'b110000,
  parameter logic [WIDTH-1:0] GAL_POLY   = 6'b100001,
  parameter int unsigned      STEPS      = 6,
  parameter int unsigned      OUT_W      = 2,
  parameter logic [WIDTH-1:0] RESET_SEED = 6'b000001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load_seed,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             mode,
  output logic [WIDTH-1:0] data_out,
  output logic [OUT_W-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             seed_err
);

  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  state_e           fsm;
  logic [CNT_W-1:0] cnt;
  logic             mode_q;
  logic [WIDTH-1:0] next_state;

  lfsr_step #(
    .WIDTH    (WIDTH),
    .FIB_TAPS (FIB_TAPS),
    .GAL_POLY (GAL_POLY)
  ) u_step (
    .state      (data_out),
    .mode       (mode_q),
    .next_state (next_state)
  );

  // Control FSM, step counter and all output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm      <= IDLE;
      cnt      <= '0;
      mode_q   <= MODE_FIB;
      data_out <= RESET_SEED;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      seed_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          // A seed load takes priority; a simultaneous start is dropped.
          if (load_seed) begin
            if (seed_in == '0) begin
              data_out <= '1;
              seed_err <= 1'b1;
            end else begin
              data_out <= seed_in;
              seed_err <= 1'b0;
            end
          end else if (start) begin
            mode_q <= mode;
            cnt    <= '0;
            busy   <= 1'b1;
            fsm    <= SHIFT;
          end
        end
        SHIFT: begin
          data_out <= next_state;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            result <= next_state[OUT_W-1:0];
            done   <= 1'b1;
            fsm    <= DONE;
          end
        end
        DONE: begin
          busy <= 1'b0;
          fsm  <= IDLE;
        end
        default: begin
          busy <= 1'b0;
          fsm  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rand_lfsr_gen.sv
// Randomised and directed bench for rand_lfsr_gen against a per-draw reference model.
module tb_rand_lfsr_gen;

  localparam int W     = 6;
  localparam int OW    = 2;
  localparam int STEPS = 6;
  localparam logic [W-1:0] FIB_TAPS   = 6'b110000;
  localparam logic [W-1:0] GAL_POLY   = 6'b100001;
  localparam logic [W-1:0] RESET_SEED = 6'b000001;

  typedef struct {
    logic [W-1:0]  st;
    logic [OW-1:0] res;
    logic          busy;
    logic          done;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          load_seed = 1'b0;
  logic [W-1:0]  seed_in = '0;
  logic          mode = 1'b0;
  logic [W-1:0]  data_out;
  logic [OW-1:0] result;
  logic          busy;
  logic          done;
  logic          seed_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   armed    = 1'b0;
  exp_t cur;
  exp_t pend_q[$];

  rand_lfsr_gen dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_seed (load_seed),
    .seed_in   (seed_in),
    .mode      (mode),
    .data_out  (data_out),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .seed_err  (seed_err)
  );

  always #5 clk = ~clk;

  // Fibonacci advance: double the value (dropping the MSB) and add the tap parity.
  function automatic logic [W-1:0] model_fib(input logic [W-1:0] s);
    int par = 0;
    for (int i = 0; i < W; i++) if (FIB_TAPS[i] && s[i]) par++;
    return W'((int'(s) * 2) % (1 << W) + (par % 2));
  endfunction

  // Galois advance: double the value; if it overflowed, fold in the polynomial.
  function automatic logic [W-1:0] model_gal(input logic [W-1:0] s);
    logic [W-1:0] d;
    d = W'((int'(s) * 2) % (1 << W));
    return (int'(s) >= (1 << (W - 1))) ? (d ^ GAL_POLY) : d;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance the model for the edge just taken.
  task automatic tick(input logic r, input logic s, input logic l,
                      input logic [W-1:0] sd, input logic m);
    exp_t e;
    logic [W-1:0] st;
    rst = r; start = s; load_seed = l; seed_in = sd; mode = m;
    @(posedge clk);
    #1;
    if (r) begin
      pend_q.delete();
      cur = '{st: RESET_SEED, res: '0, busy: 1'b0, done: 1'b0, err: 1'b0};
    end else if (pend_q.size() > 0) begin
      cur = pend_q.pop_front();
    end else if (l) begin
      cur.st  = (sd == '0) ? '1 : sd;
      cur.err = (sd == '0);
    end else if (s) begin
      // Expand the whole draw into the per-cycle outputs it will show.
      st     = cur.st;
      e      = cur;
      e.busy = 1'b1;
      e.done = 1'b0;
      cur    = e;
      for (int i = 1; i <= STEPS; i++) begin
        st   = m ? model_gal(st) : model_fib(st);
        e.st = st;
        if (i == STEPS) begin
          e.res  = st[OW-1:0];
          e.done = 1'b1;
        end
        pend_q.push_back(e);
      end
      e.busy = 1'b0;
      e.done = 1'b0;
      pend_q.push_back(e);
    end
    rst = 1'b0; start = 1'b0; load_seed = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (armed) begin
      cmp("data_out", int'(data_out), int'(cur.st));
      cmp("result",   int'(result),   int'(cur.res));
      cmp("busy",     int'(busy),     int'(cur.busy));
      cmp("done",     int'(done),     int'(cur.done));
      cmp("seed_err", int'(seed_err), int'(cur.err));
    end
  end

  initial begin
    int busy_cnt;
    int done_seen;
    logic [W-1:0] sd;

    // Model pins against hand-computed steps.
    cmp("pin_fib_a", int'(model_fib(6'b011000)), int'(6'b110001));
    cmp("pin_fib_b", int'(model_fib(6'b110001)), int'(6'b100010));
    cmp("pin_gal_a", int'(model_gal(6'b100000)), int'(6'b100001));
    cmp("pin_gal_b", int'(model_gal(6'b000100)), int'(6'b001000));

    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    armed = 1'b1;
    cmp("rst_data",  int'(data_out), int'(6'b000001));
    cmp("rst_res",   int'(result),   0);
    cmp("rst_busy",  int'(busy),     0);
    cmp("rst_done",  int'(done),     0);
    cmp("rst_err",   int'(seed_err), 0);

    // Fibonacci draw from 000011, busy length and mid-sequence value.
    tick(1'b0, 1'b0, 1'b1, 6'b000011, 1'b0);
    tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
    busy_cnt = int'(busy);
    for (int i = 1; i <= STEPS + 1; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
      busy_cnt += int'(busy);
      if (i == 4) cmp("fib_mid", int'(data_out), int'(6'b110001));
    end
    cmp("fib_busy_len", busy_cnt, STEPS + 1);
    cmp("fib_data", int'(data_out), int'(6'b000101));
    cmp("fib_res",  int'(result),   int'(2'b01));

    // Galois draw from 000001.
    tick(1'b0, 1'b0, 1'b1, 6'b000001, 1'b0);
    tick(1'b0, 1'b1, 1'b0, '0, 1'b1);
    idle(STEPS + 1);
    cmp("gal_data", int'(data_out), int'(6'b100001));
    cmp("gal_res",  int'(result),   int'(2'b01));

    // Zero-seed guard.
    tick(1'b0, 1'b0, 1'b1, 6'b000000, 1'b0);
    cmp("zero_data", int'(data_out), int'(6'b111111));
    cmp("zero_err",  int'(seed_err), 1);
    tick(1'b0, 1'b0, 1'b1, 6'b000101, 1'b0);
    cmp("reload_err", int'(seed_err), 0);

    // Load and start together: load wins.
    tick(1'b0, 1'b1, 1'b1, 6'b000101, 1'b0);
    cmp("ls_data", int'(data_out), int'(6'b000101));
    cmp("ls_busy", int'(busy), 0);

    // start/load during SHIFT are ignored.
    tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 6'b111000, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 6'b000000, 1'b1);
    idle(STEPS - 1);
    cmp("ign_data", int'(data_out), int'(6'b001111));
    cmp("ign_res",  int'(result),   int'(2'b11));
    cmp("ign_err",  int'(seed_err), 0);

    // Reset during the third SHIFT cycle aborts the draw.
    tick(1'b0, 1'b1, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cmp("abort_busy", int'(busy),     0);
    cmp("abort_data", int'(data_out), int'(6'b000001));
    cmp("abort_res",  int'(result),   0);
    done_seen = 0;
    for (int i = 0; i < STEPS + 2; i++) begin
      tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
      done_seen += int'(done);
    end
    cmp("abort_no_done", done_seen, 0);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      sd = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      tick(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 5) == 0),
           sd,
           1'($urandom_range(0, 1)));
    end
    idle(STEPS + 3);

    armed = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
